vliw_fetch_stage: RTL and testbench

- Front end of the two-slot VLIW core; it sits directly upstream of the instruction memory and register file.
- Holds the PC and drives the instruction memory address. Captures the returned 32-bit bundle into the IF/ID register.
- Splits the bundle into R slot (bits 31:16) and S slot (bits 15:0) and decodes both slots' register fields and write enables for the dual-write-port register file.
- Handles stall, redirect/flush, end-of-program halt and same-destination write conflicts.

---
 rtl/vliw_fetch_if.sv | 16 +
 rtl/vliw_fetch_stage.sv | 133 +++++++++++++
 tb/tb_vliw_fetch_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vliw_fetch_if.sv
// Instruction memory bus between the fetch stage and the bundle store.
// Ports: imem_pc (fetch -> memory), imem_ir (memory -> fetch).
interface vliw_fetch_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_ir;

  modport master (
    output imem_pc,
    input  imem_ir
  );

  modport slave (
    input  imem_pc,
    output imem_ir
  );
endinterface

// File: rtl/vliw_fetch_stage.sv
// Two-slot VLIW fetch: PC, IF/ID register, slot decode, halt/redirect.
// Ports: clk, reset, stall, redirect_*, imem bus, IF/ID + decode outputs.
module vliw_fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'd0,
  parameter int          PC_STEP    = 2,
  parameter int          IMEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  vliw_fetch_if.master imem,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_bundle,
  output logic [2:0]  r_rd,
  output logic [2:0]  r_rm,
  output logic [2:0]  r_rn,
  output logic [2:0]  s_rd,
  output logic [2:0]  s_rm,
  output logic [2:0]  s_rn,
  output logic        r_wr_en,
  output logic        s_wr_en,
  output logic        wr_conflict,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(PC_STEP * IMEM_WORDS);
  localparam logic [31:0] STEP     = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT_PEND,
    HALT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_n;
  logic [31:0] ipc_n;
  logic [31:0] bun_n;
  logic [15:0] cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_bundle   <= 32'd0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_valid    <= valid_n;
      if_pc       <= ipc_n;
      if_bundle   <= bun_n;
      fetch_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = if_valid;
    ipc_n   = if_pc;
    bun_n   = if_bundle;
    cnt_n   = fetch_count;
    if (redirect_valid) begin
      pc_n    = redirect_pc;
      valid_n = 1'b0;
      state_n = RUN;
    end else if (state == IDLE) begin
      valid_n = 1'b0;
      state_n = RUN;
    end else if (state == HALT) begin
      valid_n = 1'b0;
    end else if (!stall) begin
      unique case (state)
        RUN: begin
          if (pc >= PC_LIMIT) begin
            valid_n = 1'b0;
            state_n = HALT;
          end else begin
            bun_n   = imem.imem_ir;
            ipc_n   = pc;
            valid_n = 1'b1;
            if (fetch_count != 16'hFFFF)
              cnt_n = fetch_count + 16'd1;
            // HALT op: keep the PC parked on the halting bundle
            if (imem.imem_ir[31:28] == 4'hF)
              state_n = HALT_PEND;
            else
              pc_n = pc + STEP;
          end
        end
        HALT_PEND: begin
          valid_n = 1'b0;
          state_n = HALT;
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_pc = pc;
  assign halted       = (state == HALT);

  logic [3:0] r_op, s_op;
  logic       s_wr_en_raw;

  assign r_op = if_bundle[31:28];
  assign r_rd = if_bundle[27:25];
  assign r_rm = if_bundle[24:22];
  assign r_rn = if_bundle[21:19];
  assign s_op = if_bundle[15:12];
  assign s_rd = if_bundle[11:9];
  assign s_rm = if_bundle[8:6];
  assign s_rn = if_bundle[5:3];

  assign r_wr_en = if_valid && r_op != 4'h0
                && r_op != 4'hF && r_rd != 3'd0;
  assign s_wr_en_raw = if_valid && s_op != 4'h0
                    && s_op != 4'hF && s_rd != 3'd0;
  // Same destination: R slot wins, S write is dropped
  assign wr_conflict = r_wr_en && s_wr_en_raw
                    && (r_rd == s_rd);
  assign s_wr_en = s_wr_en_raw && !wr_conflict;

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Bench for vliw_fetch_stage: directed plan plus random stall/redirect.
// Ports: drives clk/reset/stall/redirect and a modelled instruction memory.
module tb_vliw_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, r_wr_en, s_wr_en, wr_conflict, halted;
  logic [31:0] if_pc, if_bundle;
  logic [2:0]  r_rd, r_rm, r_rn, s_rd, s_rm, s_rn;
  logic [15:0] fetch_count;
  logic [31:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  vliw_fetch_if bus ();
  assign bus.imem_ir = mem[bus.imem_pc[4:1]];

  vliw_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(bus.master),
    .if_valid(if_valid), .if_pc(if_pc), .if_bundle(if_bundle),
    .r_rd(r_rd), .r_rm(r_rm), .r_rn(r_rn),
    .s_rd(s_rd), .s_rm(s_rm), .s_rn(s_rn),
    .r_wr_en(r_wr_en), .s_wr_en(s_wr_en),
    .wr_conflict(wr_conflict), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: bubble/pending/halted flags and the IF/ID contents
  logic [31:0] m_pc, m_ipc, m_bun;
  logic [15:0] m_cnt;
  logic        m_valid, m_bubble, m_pend, m_halt;

  task automatic model_update();
    logic [31:0] w;
    if (reset) begin
      m_pc = 0; m_ipc = 0; m_bun = 0; m_cnt = 0;
      m_valid = 0; m_bubble = 1; m_pend = 0; m_halt = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0;
      m_bubble = 0; m_pend = 0; m_halt = 0;
    end else if (m_bubble) begin
      m_bubble = 0; m_valid = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (stall) begin
      // everything holds
    end else if (m_pend) begin
      m_pend = 0; m_halt = 1; m_valid = 0;
    end else if (m_pc >= 32) begin
      m_valid = 0; m_halt = 1;
    end else begin
      w = mem[m_pc[4:1]];
      m_bun = w; m_ipc = m_pc; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (w[31:28] == 4'hF) m_pend = 1;
      else m_pc = m_pc + 2;
    end
  endtask

  // Expected {conflict, s_we, r_we} from a bundle, written slot-wise
  function automatic logic [2:0] exp_we(logic [31:0] b, logic v);
    logic rw, sw, cf;
    rw = v && (b[31:28] inside {[4'h1:4'hE]}) && b[27:25] != 0;
    sw = v && (b[15:12] inside {[4'h1:4'hE]}) && b[11:9] != 0;
    cf = rw && sw && b[27:25] == b[11:9];
    return {cf, sw && !cf, rw};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pc", bus.imem_pc, m_pc);
    chk("valid", 32'(if_valid), 32'(m_valid));
    chk("if_pc", if_pc, m_ipc);
    chk("bundle", if_bundle, m_bun);
    chk("count", 32'(fetch_count), 32'(m_cnt));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fields", 32'({r_rd, r_rm, r_rn, s_rd, s_rm, s_rn}),
        32'({m_bun[27:19], m_bun[11:3]}));
    chk("we", 32'({wr_conflict, s_wr_en, r_wr_en}),
        32'(exp_we(m_bun, m_valid)));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_word(int f_chance);
    logic [31:0] w;
    w = $urandom;
    if (w[31:28] == 4'hF) w[31:28] = 4'h1;
    if (f_chance > 0 && $urandom_range(0, f_chance - 1) == 0)
      w[31:28] = 4'hF;
    return w;
  endfunction

  initial begin
    logic [31:0] hold_pc, hold_bun, last_pc;
    logic [15:0] hold_cnt;
    for (int i = 0; i < 16; i++) mem[i] = rand_word(0);
    mem[0] = 32'h5E9C_0000;
    mem[1] = 32'h0000_4269;
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;

    // reset state
    step();
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", bus.imem_pc, 0);
    chk("rst_count", 32'(fetch_count), 0);
    chk("rst_halted", 32'(halted), 0);
    reset = 0;

    // IDLE bubble, then word0 and word1
    step();
    chk("idle_valid", 32'(if_valid), 0);
    step();
    chk("f0_pc", if_pc, 0);
    chk("f0_bun", if_bundle, 32'h5E9C_0000);
    step();
    chk("f1_pc", if_pc, 2);
    chk("f1_bun", if_bundle, 32'h0000_4269);
    chk("f1_count", 32'(fetch_count), 2);

    // stall three cycles
    stall = 1;
    hold_pc = bus.imem_pc; hold_bun = if_bundle; hold_cnt = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.imem_pc, hold_pc);
      chk("stall_bun", if_bundle, hold_bun);
      chk("stall_cnt", 32'(fetch_count), 32'(hold_cnt));
    end
    stall = 0;
    step();
    chk("resume_pc", if_pc, 4);
    chk("resume_bun", if_bundle, mem[2]);

    // redirect during stall
    stall = 1; redirect_valid = 1; redirect_pc = 8;
    step();
    chk("rd_valid", 32'(if_valid), 0);
    chk("rd_pc", bus.imem_pc, 8);
    stall = 0; redirect_valid = 0;
    step();
    chk("rd_if_pc", if_pc, 8);
    chk("rd_bun", if_bundle, mem[4]);

    // run off the end of memory
    last_pc = if_pc;
    for (int i = 0; i < 40 && !halted; i++) begin
      step();
      if (if_valid) last_pc = if_pc;
    end
    chk("end_halted", 32'(halted), 1);
    chk("end_last_pc", last_pc, 30);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("end_stay", 32'({halted, if_valid}), 32'b10);
    end
    redirect_valid = 1; redirect_pc = 0;
    step();
    chk("rdh_halted", 32'(halted), 0);
    redirect_valid = 0;
    step();
    chk("rdh_bun", if_bundle, mem[0]);

    // write-port conflict decode
    mem[5] = 32'h4A00_3A00;
    mem[6] = 32'h4A00_3600;
    mem[7] = 32'h4000_3A00;
    redirect_valid = 1; redirect_pc = 10;
    step();
    redirect_valid = 0;
    step();
    chk("cf_same", 32'({r_wr_en, wr_conflict, s_wr_en}), 32'b110);
    step();
    chk("cf_diff", 32'({r_wr_en, wr_conflict, s_wr_en}), 32'b101);
    step();
    chk("cf_r0", 32'({r_wr_en, wr_conflict, s_wr_en}), 32'b001);

    // HALT op at word3
    mem[3] = 32'hF000_0000;
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) step();
    step();
    chk("hop_valid", 32'(if_valid), 1);
    chk("hop_pc", if_pc, 6);
    chk("hop_rwe", 32'(r_wr_en), 0);
    step();
    chk("hop_pend", 32'(if_valid), 0);
    step();
    chk("hop_halted", 32'(halted), 1);
    chk("hop_frozen", bus.imem_pc, 6);
    step();
    reset = 1;
    step();
    chk("hrst_pc", bus.imem_pc, 0);
    chk("hrst_cnt", 32'(fetch_count), 0);
    reset = 0;
    step();
    chk("hrst_idle", 32'(if_valid), 0);

    // random stall / redirect / reset against the model
    for (int i = 0; i < 16; i++) mem[i] = rand_word(8);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = 32'($urandom_range(0, 18)) * 2;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
